// File: rtl/aclk_ascii_key_decoder_if.sv
// Valid/ready byte stream carrying ASCII key codes into the digit-entry decoder.
interface aclk_ascii_key_decoder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, in_valid, input  in_ready);
  modport slave  (input  in_data, in_valid, output in_ready);
endinterface

// File: rtl/aclk_ascii_key_decoder.sv
// ASCII key stream -> HHMM digit buffer with commit/backspace/escape/timeout.
// Optional macro ACLK_KEY_ALARM_EN adds the 'A' key, which commits to the alarm via load_alarm.
module aclk_ascii_key_decoder #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic        clock,
  input  logic        reset,
  aclk_ascii_key_decoder_if.slave kif,
  output logic [3:0]  key,
  output logic [15:0] new_time,
  output logic [2:0]  digit_count,
  output logic        show_new_time,
  output logic        load_new_time,
`ifdef ACLK_KEY_ALARM_EN
  output logic        load_alarm,
`endif
  output logic        key_error
);

  typedef enum logic [1:0] {IDLE, ENTRY, FULL, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       key_q, key_d;
  logic [15:0]      nt_q, nt_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             load_q, load_d;
  logic             err_q, err_d;
  logic             alarm_q, alarm_d;
  logic             rdy, xfer, is_digit;

  assign rdy      = (state_q != COMMIT);
  assign xfer     = kif.in_valid && rdy;
  assign is_digit = (kif.in_data >= 8'h30) && (kif.in_data <= 8'h39);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      nt_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nt_q    <= nt_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      load_q  <= load_d;
      err_q   <= err_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    nt_d    = nt_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    alarm_d = 1'b0;
    case (state_q)
      // Buffer stays visible through the commit cycle, cleared on the way out.
      COMMIT: begin
        state_d = IDLE;
        nt_d    = '0;
        cnt_d   = '0;
        tmo_d   = '0;
      end
      default: begin
        if (xfer) begin
          tmo_d = '0;
          if (is_digit) begin
            if (state_q == FULL) err_d = 1'b1;
            else begin
              nt_d    = {nt_q[11:0], kif.in_data[3:0]};
              key_d   = kif.in_data[3:0];
              cnt_d   = cnt_q + 3'd1;
              state_d = (cnt_q == 3'd3) ? FULL : ENTRY;
            end
          end else begin
            case (kif.in_data)
              8'h0D: begin
                if (state_q == FULL) begin
                  state_d = COMMIT;
                  load_d  = 1'b1;
                end else err_d = 1'b1;
              end
`ifdef ACLK_KEY_ALARM_EN
              8'h41: begin
                if (state_q == FULL) begin
                  state_d = COMMIT;
                  alarm_d = 1'b1;
                end else err_d = 1'b1;
              end
`endif
              8'h08: begin
                if (state_q != IDLE) begin
                  nt_d    = {4'h0, nt_q[15:4]};
                  key_d   = nt_q[7:4];
                  cnt_d   = cnt_q - 3'd1;
                  state_d = (cnt_q == 3'd1) ? IDLE : ENTRY;
                end
              end
              8'h1B: begin
                state_d = IDLE;
                nt_d    = '0;
                cnt_d   = '0;
              end
              default: err_d = 1'b1;
            endcase
          end
        end else if (state_q != IDLE) begin
          if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            nt_d    = '0;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else begin
          tmo_d = '0;
        end
      end
    endcase
  end

  assign kif.in_ready  = rdy;
  assign key           = key_q;
  assign new_time      = nt_q;
  assign digit_count   = cnt_q;
  assign show_new_time = (cnt_q != 3'd0);
  assign load_new_time = load_q;
  assign key_error     = err_q;
`ifdef ACLK_KEY_ALARM_EN
  assign load_alarm    = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm  = alarm_q;
`endif

endmodule
